// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline types and constants
package mips_pipe_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-low reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_stall_hazard,
    input  logic             flush,
    input  logic             valid_ID,
    input  logic [DW-1:0]    PC_ID,
    input  logic [AW-1:0]    Rs_ID,
    input  logic [AW-1:0]    Rt_ID,
    input  logic [AW-1:0]    Rd_ID,
    input  logic [DW-1:0]    regA_ID,
    input  logic [DW-1:0]    regB_ID,
    input  logic [DW-1:0]    imm_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             RegDst_ID,
    input  logic             ALUSrc_ID,
    input  logic             MemtoReg_ID,
    input  logic [3:0]       ALUop_ID,
    output logic             valid_EXE,
    output logic [DW-1:0]    PC_EXE,
    output logic [DW-1:0]    regA_EXE,
    output logic [DW-1:0]    regB_EXE,
    output logic [DW-1:0]    imm_EXE,
    output logic [AW-1:0]    Rs_EXE,
    output logic [AW-1:0]    Rt_EXE,
    output logic [AW-1:0]    RegWr_EXE,
    output logic             RegWrite_EXE,
    output logic             MemRead_EXE,
    output logic             MemWrite_EXE,
    output logic             ALUSrc_EXE,
    output logic             MemtoReg_EXE,
    output logic [3:0]       ALUop_EXE,
    output logic             load_control,
    output logic [CNT_W-1:0] bubble_count
);

    logic          bubble;
    logic          live;
    logic          load_bubble;
    ex_ctrl_t      ctrl_next;
    ex_ctrl_t      ctrl_q;
    logic [AW-1:0] dest_next;
    logic          load_next;

    assign bubble      = flush | ID_stall_hazard;
    assign live        = ~bubble & valid_ID;
    // Flush wins over a coincident stall, and its bubble is not a load-use bubble.
    assign load_bubble = ID_stall_hazard & ~flush;

    always_comb begin
        ctrl_next = EX_CTRL_BUBBLE;
        dest_next = '0;
        load_next = 1'b0;
        if (live) begin
            ctrl_next.reg_write  = RegWrite_ID;
            ctrl_next.mem_read   = MemRead_ID;
            ctrl_next.mem_write  = MemWrite_ID;
            ctrl_next.mem_to_reg = MemtoReg_ID;
            ctrl_next.alu_src    = ALUSrc_ID;
            ctrl_next.alu_op     = ALUop_ID;
            if (RegWrite_ID) begin
                dest_next = RegDst_ID ? Rd_ID : Rt_ID;
            end
            // A load into $0 must never trigger a stall downstream.
            load_next = MemRead_ID & RegWrite_ID & (dest_next != AW'(REG_ZERO));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_EXE    <= 1'b0;
            PC_EXE       <= '0;
            regA_EXE     <= '0;
            regB_EXE     <= '0;
            imm_EXE      <= '0;
            Rs_EXE       <= '0;
            Rt_EXE       <= '0;
            RegWr_EXE    <= '0;
            ctrl_q       <= EX_CTRL_BUBBLE;
            load_control <= 1'b0;
        end else begin
            valid_EXE    <= live;
            RegWr_EXE    <= dest_next;
            ctrl_q       <= ctrl_next;
            load_control <= load_next;
            if (bubble) begin
                PC_EXE   <= '0;
                regA_EXE <= '0;
                regB_EXE <= '0;
                imm_EXE  <= '0;
                Rs_EXE   <= '0;
                Rt_EXE   <= '0;
            end else begin
                PC_EXE   <= PC_ID;
                regA_EXE <= regA_ID;
                regB_EXE <= regB_ID;
                imm_EXE  <= imm_ID;
                Rs_EXE   <= Rs_ID;
                Rt_EXE   <= Rt_ID;
            end
        end
    end

    assign RegWrite_EXE = ctrl_q.reg_write;
    assign MemRead_EXE  = ctrl_q.mem_read;
    assign MemWrite_EXE = ctrl_q.mem_write;
    assign MemtoReg_EXE = ctrl_q.mem_to_reg;
    assign ALUSrc_EXE   = ctrl_q.alu_src;
    assign ALUop_EXE    = ctrl_q.alu_op;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_bubble_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_bubble),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
    import mips_pipe_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ID_stall_hazard, flush, valid_ID;
    logic [DW-1:0]    PC_ID, regA_ID, regB_ID, imm_ID;
    logic [AW-1:0]    Rs_ID, Rt_ID, Rd_ID;
    logic             RegWrite_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID, MemtoReg_ID;
    logic [3:0]       ALUop_ID;
    logic             valid_EXE;
    logic [DW-1:0]    PC_EXE, regA_EXE, regB_EXE, imm_EXE;
    logic [AW-1:0]    Rs_EXE, Rt_EXE, RegWr_EXE;
    logic             RegWrite_EXE, MemRead_EXE, MemWrite_EXE, ALUSrc_EXE, MemtoReg_EXE;
    logic [3:0]       ALUop_EXE;
    logic             load_control;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ID_stall_hazard(ID_stall_hazard), .flush(flush),
        .valid_ID(valid_ID), .PC_ID(PC_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .regA_ID(regA_ID), .regB_ID(regB_ID), .imm_ID(imm_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .RegDst_ID(RegDst_ID), .ALUSrc_ID(ALUSrc_ID), .MemtoReg_ID(MemtoReg_ID),
        .ALUop_ID(ALUop_ID), .valid_EXE(valid_EXE), .PC_EXE(PC_EXE), .regA_EXE(regA_EXE),
        .regB_EXE(regB_EXE), .imm_EXE(imm_EXE), .Rs_EXE(Rs_EXE), .Rt_EXE(Rt_EXE),
        .RegWr_EXE(RegWr_EXE), .RegWrite_EXE(RegWrite_EXE), .MemRead_EXE(MemRead_EXE),
        .MemWrite_EXE(MemWrite_EXE), .ALUSrc_EXE(ALUSrc_EXE), .MemtoReg_EXE(MemtoReg_EXE),
        .ALUop_EXE(ALUop_EXE), .load_control(load_control), .bubble_count(bubble_count)
    );

    typedef struct {
        logic             valid;
        logic [DW-1:0]    pc, rega, regb, imm;
        logic [AW-1:0]    rs, rt, regwr;
        logic             regwrite, memread, memwrite, alusrc, memtoreg;
        logic [3:0]       aluop;
        logic             load;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               n_vec  = 0;
    int               n_miss = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [AW-1:0] dst;
        e = '{default: '0};
        if (!(flush || ID_stall_hazard)) begin
            e.valid = valid_ID;
            e.pc    = PC_ID;
            e.rega  = regA_ID;
            e.regb  = regB_ID;
            e.imm   = imm_ID;
            e.rs    = Rs_ID;
            e.rt    = Rt_ID;
            if (valid_ID) begin
                e.regwrite = RegWrite_ID;
                e.memread  = MemRead_ID;
                e.memwrite = MemWrite_ID;
                e.alusrc   = ALUSrc_ID;
                e.memtoreg = MemtoReg_ID;
                e.aluop    = ALUop_ID;
                dst        = RegDst_ID ? Rd_ID : Rt_ID;
                e.regwr    = RegWrite_ID ? dst : '0;
                e.load     = MemRead_ID && RegWrite_ID && (e.regwr != 0);
            end
        end
        if (ID_stall_hazard && !flush && model_cnt != CNT_MAX) model_cnt++;
        e.cnt = model_cnt;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("valid_EXE",    valid_EXE,    e.valid);
            chk("PC_EXE",       PC_EXE,       e.pc);
            chk("regA_EXE",     regA_EXE,     e.rega);
            chk("regB_EXE",     regB_EXE,     e.regb);
            chk("imm_EXE",      imm_EXE,      e.imm);
            chk("Rs_EXE",       Rs_EXE,       e.rs);
            chk("Rt_EXE",       Rt_EXE,       e.rt);
            chk("RegWr_EXE",    RegWr_EXE,    e.regwr);
            chk("RegWrite_EXE", RegWrite_EXE, e.regwrite);
            chk("MemRead_EXE",  MemRead_EXE,  e.memread);
            chk("MemWrite_EXE", MemWrite_EXE, e.memwrite);
            chk("ALUSrc_EXE",   ALUSrc_EXE,   e.alusrc);
            chk("MemtoReg_EXE", MemtoReg_EXE, e.memtoreg);
            chk("ALUop_EXE",    ALUop_EXE,    e.aluop);
            chk("load_control", load_control, e.load);
            chk("bubble_count", bubble_count, e.cnt);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},  valid_EXE, 0);
        chk({tag, "_data"},   {PC_EXE | regA_EXE | regB_EXE | imm_EXE}, 0);
        chk({tag, "_regs"},   {Rs_EXE, Rt_EXE, RegWr_EXE}, 0);
        chk({tag, "_ctrl"},   {RegWrite_EXE, MemRead_EXE, MemWrite_EXE, ALUSrc_EXE, MemtoReg_EXE, ALUop_EXE}, 0);
        chk({tag, "_load"},   load_control, 0);
        chk({tag, "_count"},  bubble_count, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        push_expected();
        @(posedge clk);
        #1;
        compare_front();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic [DW-1:0] pc,
                             input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                             input logic rw, input logic mr, input logic mw, input logic rdst,
                             input logic asrc, input logic m2r, input logic [3:0] op);
        valid_ID = v; PC_ID = pc; Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
        regA_ID = a; regB_ID = b; imm_ID = imm;
        RegWrite_ID = rw; MemRead_ID = mr; MemWrite_ID = mw; RegDst_ID = rdst;
        ALUSrc_ID = asrc; MemtoReg_ID = m2r; ALUop_ID = op;
    endtask

    initial begin
        rst_n = 1'b0;
        ID_stall_hazard = 1'b0;
        flush = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_NOP);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // lw $8, 4($29)
        set_instr(1, 32'h100, 5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'd4, 1, 1, 0, 0, 1, 1, ALU_ADD);
        step();
        chk("lw_regwr", RegWr_EXE, 8);
        chk("lw_load", load_control, 1);

        // add $3,$8,$2 held in ID through one load-use stall
        set_instr(1, 32'h104, 5'd8, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1, 0, 0, 1, 0, 0, ALU_ADD);
        ID_stall_hazard = 1'b1;
        step();
        chk("stall_load", load_control, 0);
        chk("stall_count", bubble_count, 1);
        ID_stall_hazard = 1'b0;
        step();
        chk("add_regwr", RegWr_EXE, 3);
        chk("add_aluop", ALUop_EXE, ALU_ADD);

        // lw $0 must not raise load_control
        set_instr(1, 32'h108, 5'd4, 5'd0, 5'd0, 32'h55, 32'h0, 32'd8, 1, 1, 0, 0, 1, 1, ALU_ADD);
        step();
        chk("lw0_load", load_control, 0);

        // flush + stall, then flush alone: bubbles, not counted
        set_instr(1, 32'h10c, 5'd1, 5'd2, 5'd7, 32'h9, 32'h8, 32'h7, 1, 0, 1, 1, 0, 0, ALU_SUB);
        flush = 1'b1; ID_stall_hazard = 1'b1;
        step();
        ID_stall_hazard = 1'b0;
        step();
        chk("flush_count", bubble_count, 1);
        flush = 1'b0;

        // invalid ID: data captured, controls zero
        set_instr(0, 32'h110, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 1, 1, 1, 1, 1, 1, ALU_OR);
        step();

        // four more stalls bring the count to 5, then a live load
        set_instr(1, 32'h114, 5'd9, 5'd10, 5'd11, 32'h1, 32'h2, 32'h3, 1, 0, 0, 1, 0, 0, ALU_AND);
        ID_stall_hazard = 1'b1;
        repeat (4) step();
        ID_stall_hazard = 1'b0;
        set_instr(1, 32'h118, 5'd29, 5'd9, 5'd0, 32'h2000, 32'h0, 32'd12, 1, 1, 0, 0, 1, 1, ALU_ADD);
        push_expected();
        @(posedge clk);
        #1;
        compare_front();
        chk("pre_reset_load", load_control, 1);
        chk("pre_reset_count", bubble_count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        set_instr(1, 32'h200, 5'd12, 5'd13, 5'd14, 32'hCAFE, 32'hBEEF, 32'h0, 1, 0, 0, 1, 0, 0, ALU_SLT);
        step();
        chk("post_reset_regwr", RegWr_EXE, 14);

        // saturation: 17 stalls from zero
        ID_stall_hazard = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 15) chk("sat_at_15", bubble_count, 15);
        end
        chk("sat_hold", bubble_count, 15);
        ID_stall_hazard = 1'b0;

        // random mix
        for (int i = 0; i < 24; i++) begin
            set_instr(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 5'($urandom),
                      5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 5)));
            ID_stall_hazard = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            step();
        end
        ID_stall_hazard = 1'b0;
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Consumes the load-use stall from the hazard detection unit: on a stall it inserts a bubble into EXE.
- Produces the hazard unit's inputs:
  - the registered destination register (RegWr_EXE);
  - the registered load flag (load_control).
- Also maintains a saturating count of inserted load-use bubbles for performance debug.

Parameters:
- DW, 32, datapath width (PC, register operands, immediate).
- AW, 5, register-number width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_stall_hazard  in  1  load-use stall from the hazard unit; insert bubble this cycle.
- flush  in  1  branch/jump redirect; kill the instruction in ID.
- valid_ID  in  1  ID holds a real instruction.
- PC_ID  in  DW  PC of the ID instruction.
- Rs_ID, Rt_ID, Rd_ID  in  AW each  register numbers.
- regA_ID, regB_ID  in  DW each  register file read data.
- imm_ID  in  DW  sign/zero-extended immediate.
- RegWrite_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID, MemtoReg_ID  in  1 each  decoded controls.
- ALUop_ID  in  4  ALU operation.
- valid_EXE  out  1  EXE holds a real instruction.
- PC_EXE, regA_EXE, regB_EXE, imm_EXE  out  DW  registered copies.
- Rs_EXE, Rt_EXE  out  AW  registered copies, for the forwarding unit.
- RegWr_EXE  out  AW  destination register of the EXE instruction: Rd if RegDst else Rt.
- RegWrite_EXE, MemRead_EXE, MemWrite_EXE, ALUSrc_EXE, MemtoReg_EXE  out  1 each.
- ALUop_EXE  out  4.
- load_control  out  1  EXE instruction is a load that writes a nonzero register.
- bubble_count  out  CNT_W  number of load-use bubbles inserted since reset.

Behaviour:
- Reset (async assert, synchronous-safe release):
  - all outputs 0, including valid_EXE, RegWr_EXE, load_control and bubble_count;
  - state equals a bubble.
- Latency: 1 cycle. ID inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority: flush > ID_stall_hazard > normal capture.
- Bubble (flush=1, or ID_stall_hazard=1):
  - valid_EXE ← 0;
  - all control outputs ← 0: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst-derived RegWr_EXE, ALUop ← 4'b0000 (NOP);
  - load_control ← 0;
  - data fields (PC, regA, regB, imm, Rs, Rt) ← 0, so no stale operand is visible.
- Normal capture:
  - all fields ← ID values; valid_EXE ← valid_ID;
  - if valid_ID=0, controls are forced to 0 exactly as for a bubble.
- RegWr_EXE:
  - register-number width AW;
  - next = RegDst_ID ? Rd_ID : Rt_ID;
  - forced to 0 when the next cycle is a bubble, or when RegWrite_ID=0.
- load_control: next = MemRead_ID & RegWrite_ID & valid_ID & (next RegWr_EXE != 0).
  - Load to $0 never raises load_control, so no spurious stall.
- Stall loop:
  - ID holds its instruction while stalled (IF/PC stalled upstream).
  - After one bubble, load_control falls to 0 and the stall releases.
  - The held instruction is captured on the next edge.
  - Exactly one bubble is inserted per load-use.
- bubble_count:
  - +1 on each edge where ID_stall_hazard=1 and flush=0;
  - saturates at 2^CNT_W−1 with no wrap;
  - flush-induced bubbles are not counted.
- Simultaneous flush and stall: one bubble, not counted.
- Reset mid-stall: outputs clear immediately (async); counter clears.

Decomposition:
- Shared package mips_pipe_pkg contains:
  - ALU op constants, including ALU_NOP=4'b0000;
  - REG_ZERO=5'd0;
  - a packed struct ex_ctrl_t grouping RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc and ALUop, with constant EX_CTRL_BUBBLE = all-zero.
- One sub-module, sat_counter (parameter width; inputs clk, rst_n, inc; output count), implements bubble_count.

Test Plan:
- Reset release, then lw $8 with valid_ID=1, MemRead=1, RegWrite=1, RegDst=0, Rt=8 → next cycle: valid_EXE=1, RegWr_EXE=8, load_control=1, bubble_count=0.
- ID_stall_hazard=1 for one cycle with add $3,$8,$2 held in ID → next cycle: valid_EXE=0, all controls 0, RegWr_EXE=0, load_control=0, bubble_count=1. The following cycle captures add: RegWr_EXE=3 (RegDst=1, Rd=3), ALUop=add.
- lw to $0 (Rt=0, MemRead=1, RegWrite=1) → RegWr_EXE=0, load_control=0.
- flush=1 and ID_stall_hazard=1 on the same edge → bubble, bubble_count unchanged. flush alone → bubble, count unchanged.
- Preload the counter near max (CNT_W=4) by applying 17 stall cycles → bubble_count reads 15 after the 15th stall and stays 15.
- Assert rst_n=0 mid-clock while load_control=1 and bubble_count=5 → all outputs 0 immediately, before the next clk edge. After release, the first capture behaves normally.
